tlb_lookup_unit: RTL and testbench

TLB_LOOKUP_UNIT -- requirements
Module: tlb_lookup_unit

---
 rtl/tlb_lookup_unit.sv | 186 ++++++++++++++++++
 tb/tb_tlb_lookup_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_lookup_unit.sv
// Fully associative 4 KB-page TLB with one-cycle registered lookup, permission checks,
// victim-pointer or indexed fills, and a one-entry-per-cycle invalidate-all sweep.
module tlb_lookup_unit #(
   parameter int unsigned ENTRIES    = 8,
   parameter int unsigned MISS_CNT_W = 16,
   localparam int unsigned IDX_W     = $clog2(ENTRIES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_ea,
   input  logic [1:0]            req_type,
   input  logic                  req_as,
   input  logic                  req_pr,
   input  logic [7:0]            pid0,
   input  logic [7:0]            pid1,
   input  logic [7:0]            pid2,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_pa,
   output logic                  rsp_miss,
   output logic [4:0]            rsp_exc,
   input  logic                  wr_en,
   input  logic                  wr_use_victim,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic                  wr_v,
   input  logic                  wr_ts,
   input  logic [7:0]            wr_tid,
   input  logic [19:0]           wr_epn,
   input  logic [19:0]           wr_rpn,
   input  logic [5:0]            wr_perm,
   input  logic                  inv_all,
   output logic                  busy,
   output logic [MISS_CNT_W-1:0] miss_cnt
);

   typedef enum logic [0:0] {StIdle, StInval} state_e;

   state_e                  state_q;
   logic [IDX_W-1:0]        sweep_q;
   logic [IDX_W-1:0]        victim_q;
   logic                    busy_q;
   logic [ENTRIES-1:0]      v_q;
   logic                    ts_q   [ENTRIES];
   logic [7:0]              tid_q  [ENTRIES];
   logic [19:0]             epn_q  [ENTRIES];
   logic [19:0]             rpn_q  [ENTRIES];
   logic [5:0]              perm_q [ENTRIES];

   logic                    rsp_valid_q;
   logic                    rsp_miss_q;
   logic [4:0]              rsp_exc_q;
   logic [31:0]             rsp_pa_q;
   logic [MISS_CNT_W-1:0]   miss_cnt_q;

   logic [ENTRIES-1:0]      match;
   logic                    hit;
   logic [IDX_W-1:0]        hit_idx;
   logic                    is_fetch;
   logic                    is_store;
   logic                    allow;
   logic [5:0]              hit_perm;
   logic [4:0]              exc_d;
   logic [31:0]             pa_d;
   logic                    accept;
   logic                    wr_accept;
   logic [IDX_W-1:0]        wr_sel;

   assign req_ready = ~busy_q;
   assign busy      = busy_q;
   assign accept    = req_valid & ~busy_q;
   assign wr_accept = wr_en & ~busy_q;
   assign wr_sel    = wr_use_victim ? victim_q : wr_idx;

   always_comb begin
      match = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         match[i] = v_q[i] & (ts_q[i] == req_as) & (epn_q[i] == req_ea[31:12]) &
                    ((tid_q[i] == 8'h00) | (tid_q[i] == pid0) |
                     (tid_q[i] == pid1) | (tid_q[i] == pid2));
      end
   end

   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Perm layout {UX,SX,UW,SW,UR,SR}; reserved type 11 behaves as a load.
   always_comb begin
      is_fetch = (req_type == 2'b00);
      is_store = (req_type == 2'b10);
      hit_perm = perm_q[hit_idx];
      if (is_fetch) begin
         allow = req_pr ? hit_perm[5] : hit_perm[4];
      end else if (is_store) begin
         allow = req_pr ? hit_perm[3] : hit_perm[2];
      end else begin
         allow = req_pr ? hit_perm[1] : hit_perm[0];
      end
      exc_d = 5'b00000;
      pa_d  = 32'h0;
      if (!hit) begin
         exc_d = is_fetch ? 5'b00001 : 5'b00010;
      end else begin
         pa_d = {rpn_q[hit_idx], req_ea[11:0]};
         if (!allow) begin
            if (is_fetch)      exc_d = 5'b00100;
            else if (is_store) exc_d = 5'b10000;
            else               exc_d = 5'b01000;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         sweep_q     <= '0;
         busy_q      <= 1'b0;
         victim_q    <= '0;
         v_q         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_miss_q  <= 1'b0;
         rsp_exc_q   <= '0;
         rsp_pa_q    <= '0;
         miss_cnt_q  <= '0;
      end else begin
         rsp_valid_q <= accept;
         rsp_miss_q  <= accept & ~hit;
         rsp_exc_q   <= accept ? exc_d : 5'b00000;
         rsp_pa_q    <= accept ? pa_d : 32'h0;
         if (accept && !hit && (miss_cnt_q != '1)) begin
            miss_cnt_q <= miss_cnt_q + 1'b1;
         end
         if (wr_accept) begin
            v_q[wr_sel] <= wr_v;
            if (wr_use_victim) begin
               victim_q <= victim_q + 1'b1;
            end
         end
         unique case (state_q)
            StIdle: begin
               if (inv_all) begin
                  state_q <= StInval;
                  sweep_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StInval: begin
               v_q[sweep_q] <= 1'b0;
               sweep_q      <= sweep_q + 1'b1;
               if (sweep_q == IDX_W'(ENTRIES - 1)) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Entry payload carries no reset; only V gates a hit.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         ts_q[wr_sel]   <= wr_ts;
         tid_q[wr_sel]  <= wr_tid;
         epn_q[wr_sel]  <= wr_epn;
         rpn_q[wr_sel]  <= wr_rpn;
         perm_q[wr_sel] <= wr_perm;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_miss  = rsp_miss_q;
   assign rsp_exc   = rsp_exc_q;
   assign rsp_pa    = rsp_pa_q;
   assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_tlb_lookup_unit.sv
// Directed self-checking bench for tlb_lookup_unit with ENTRIES=8.
module tb_tlb_lookup_unit;

   localparam int unsigned ENTRIES = 8;
   localparam int unsigned IDX_W   = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_ea;
   logic [1:0]  req_type;
   logic        req_as;
   logic        req_pr;
   logic [7:0]  pid0, pid1, pid2;
   logic        rsp_valid;
   logic [31:0] rsp_pa;
   logic        rsp_miss;
   logic [4:0]  rsp_exc;
   logic        wr_en;
   logic        wr_use_victim;
   logic [IDX_W-1:0] wr_idx;
   logic        wr_v;
   logic        wr_ts;
   logic [7:0]  wr_tid;
   logic [19:0] wr_epn;
   logic [19:0] wr_rpn;
   logic [5:0]  wr_perm;
   logic        inv_all;
   logic        busy;
   logic [15:0] miss_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_miss = 0;

   tlb_lookup_unit #(.ENTRIES(ENTRIES), .MISS_CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_ea(req_ea), .req_type(req_type),
      .req_as(req_as), .req_pr(req_pr), .pid0(pid0), .pid1(pid1), .pid2(pid2),
      .rsp_valid(rsp_valid), .rsp_pa(rsp_pa), .rsp_miss(rsp_miss), .rsp_exc(rsp_exc),
      .wr_en(wr_en), .wr_use_victim(wr_use_victim), .wr_idx(wr_idx), .wr_v(wr_v),
      .wr_ts(wr_ts), .wr_tid(wr_tid), .wr_epn(wr_epn), .wr_rpn(wr_rpn), .wr_perm(wr_perm),
      .inv_all(inv_all), .busy(busy), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_rsp(input string tag, input logic miss, input logic [4:0] exc,
                            input logic [31:0] pa);
      check({tag, ".valid"}, {31'h0, rsp_valid}, 32'h1);
      check({tag, ".miss"}, {31'h0, rsp_miss}, {31'h0, miss});
      check({tag, ".exc"}, {27'h0, rsp_exc}, {27'h0, exc});
      check({tag, ".pa"}, rsp_pa, pa);
      if (miss) exp_miss++;
      check({tag, ".cnt"}, {16'h0, miss_cnt}, exp_miss);
   endtask

   task automatic set_wr(input logic victim, input logic [IDX_W-1:0] idx, input logic [7:0] tid,
                         input logic [19:0] epn, input logic [19:0] rpn, input logic [5:0] perm);
      wr_use_victim = victim;
      wr_idx  = idx;
      wr_v    = 1'b1;
      wr_ts   = 1'b0;
      wr_tid  = tid;
      wr_epn  = epn;
      wr_rpn  = rpn;
      wr_perm = perm;
   endtask

   task automatic do_write(input logic victim, input logic [IDX_W-1:0] idx, input logic [7:0] tid,
                           input logic [19:0] epn, input logic [19:0] rpn, input logic [5:0] perm);
      set_wr(victim, idx, tid, epn, rpn, perm);
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
   endtask

   task automatic set_req(input logic [31:0] ea, input logic [1:0] typ, input logic as_,
                          input logic pr);
      req_ea   = ea;
      req_type = typ;
      req_as   = as_;
      req_pr   = pr;
   endtask

   task automatic lookup(input logic [31:0] ea, input logic [1:0] typ, input logic as_,
                         input logic pr);
      set_req(ea, typ, as_, pr);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; wr_en = 1'b0; inv_all = 1'b0;
      set_req(32'h0, 2'b01, 1'b0, 1'b0);
      set_wr(1'b0, '0, 8'h00, 20'h0, 20'h0, 6'h0);
      pid0 = 8'h01; pid1 = 8'h02; pid2 = 8'h03;
      step(); step();
      check("reset.rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("reset.busy", {31'h0, busy}, 32'h0);
      check("reset.ready", {31'h0, req_ready}, 32'h1);
      check("reset.miss_cnt", {16'h0, miss_cnt}, 32'h0);
      rst = 1'b0;
      step();

      // Basic hit, then the response lasts exactly one cycle
      do_write(1'b0, 3'd3, 8'h00, 20'h12345, 20'hABCDE, 6'h3F);
      lookup(32'h12345678, 2'b01, 1'b0, 1'b0);
      check_rsp("hit_load", 1'b0, 5'b00000, 32'hABCDE678);
      step();
      check("one_cycle_rsp", {31'h0, rsp_valid}, 32'h0);

      lookup(32'h12345678, 2'b01, 1'b1, 1'b0);
      check_rsp("as_miss", 1'b1, 5'b00010, 32'h0);

      do_write(1'b0, 3'd3, 8'h22, 20'h12345, 20'hABCDE, 6'h3F);
      lookup(32'h12345678, 2'b00, 1'b0, 1'b0);
      check_rsp("tid_miss_fetch", 1'b1, 5'b00001, 32'h0);
      pid1 = 8'h22;
      lookup(32'h12345678, 2'b00, 1'b0, 1'b0);
      check_rsp("tid_pid1_hit", 1'b0, 5'b00000, 32'hABCDE678);
      pid1 = 8'h02;

      // Permissions with read-only entry
      do_write(1'b0, 3'd3, 8'h00, 20'h12345, 20'hABCDE, 6'b000011);
      lookup(32'h12345678, 2'b10, 1'b0, 1'b1);
      check_rsp("store_user_viol", 1'b0, 5'b10000, 32'hABCDE678);
      lookup(32'h12345678, 2'b10, 1'b0, 1'b0);
      check_rsp("store_sup_viol", 1'b0, 5'b10000, 32'hABCDE678);
      lookup(32'h12345678, 2'b00, 1'b0, 1'b0);
      check_rsp("fetch_viol", 1'b0, 5'b00100, 32'hABCDE678);
      lookup(32'h12345678, 2'b11, 1'b0, 1'b1);
      check_rsp("rsvd_load_ok", 1'b0, 5'b00000, 32'hABCDE678);
      do_write(1'b0, 3'd3, 8'h00, 20'h12345, 20'hABCDE, 6'b111100);
      lookup(32'h12345678, 2'b01, 1'b0, 1'b0);
      check_rsp("load_viol", 1'b0, 5'b01000, 32'hABCDE678);

      // Lowest index wins; a same-cycle write is not visible to the lookup
      do_write(1'b0, 3'd1, 8'h00, 20'h12345, 20'h11111, 6'h3F);
      lookup(32'h12345678, 2'b01, 1'b0, 1'b0);
      check_rsp("multi_hit", 1'b0, 5'b00000, 32'h11111678);
      set_wr(1'b0, 3'd1, 8'h00, 20'h12345, 20'h22222, 6'h3F);
      wr_en = 1'b1;
      lookup(32'h12345678, 2'b01, 1'b0, 1'b0);
      wr_en = 1'b0;
      check_rsp("pre_write_view", 1'b0, 5'b00000, 32'h11111678);
      lookup(32'h12345678, 2'b01, 1'b0, 1'b0);
      check_rsp("post_write_view", 1'b0, 5'b00000, 32'h22222678);

      // ENTRIES+1 victim writes: the last one wraps onto index 0
      for (int k = 0; k <= ENTRIES; k++) begin
         do_write(1'b1, '0, 8'h00, 20'h00100 + 20'(k), 20'h00200 + 20'(k), 6'h3F);
      end
      lookup(32'h00101ABC, 2'b01, 1'b0, 1'b0);
      check_rsp("victim_idx1", 1'b0, 5'b00000, 32'h00201ABC);
      lookup(32'h00100000, 2'b01, 1'b0, 1'b0);
      check_rsp("victim_wrap_over", 1'b1, 5'b00010, 32'h0);
      lookup(32'h00108004, 2'b01, 1'b0, 1'b0);
      check_rsp("victim_wrap_new", 1'b0, 5'b00000, 32'h00208004);
      lookup(32'h12345678, 2'b01, 1'b0, 1'b0);
      check_rsp("old_evicted", 1'b1, 5'b00010, 32'h0);

      // Invalidate sweep; request in the inv_all cycle sees pre-sweep contents
      set_req(32'h00107010, 2'b01, 1'b0, 1'b0);
      req_valid = 1'b1;
      inv_all   = 1'b1;
      step();
      req_valid = 1'b0;
      inv_all   = 1'b0;
      check_rsp("inv_cycle_req", 1'b0, 5'b00000, 32'h00207010);
      for (int i = 0; i < ENTRIES; i++) begin
         check($sformatf("sweep%0d.busy", i), {31'h0, busy}, 32'h1);
         check($sformatf("sweep%0d.ready", i), {31'h0, req_ready}, 32'h0);
         if (i >= 5) check($sformatf("sweep%0d.norsp", i), {31'h0, rsp_valid}, 32'h0);
         inv_all = (i == 3);
         if (i == 4) begin
            set_req(32'h00101000, 2'b01, 1'b0, 1'b0);
            req_valid = 1'b1;
         end
         if (i == ENTRIES - 1) begin
            set_wr(1'b0, 3'd0, 8'h00, 20'h00777, 20'h00007, 6'h3F);
            wr_en = 1'b1;
         end
         step();
      end
      req_valid = 1'b0;
      wr_en     = 1'b0;
      inv_all   = 1'b0;
      check("sweep_done.busy", {31'h0, busy}, 32'h0);
      check("sweep_done.ready", {31'h0, req_ready}, 32'h1);
      lookup(32'h00101000, 2'b01, 1'b0, 1'b0);
      check_rsp("post_inv_1", 1'b1, 5'b00010, 32'h0);
      lookup(32'h00108000, 2'b00, 1'b0, 1'b0);
      check_rsp("post_inv_0", 1'b1, 5'b00001, 32'h0);
      lookup(32'h00777000, 2'b01, 1'b0, 1'b0);
      check_rsp("dropped_write", 1'b1, 5'b00010, 32'h0);

      // Reset while a request is pending: no response
      do_write(1'b0, 3'd2, 8'h00, 20'h00222, 20'h00002, 6'h3F);
      set_req(32'h00222000, 2'b01, 1'b0, 1'b0);
      req_valid = 1'b1;
      #2 rst = 1'b1;
      step();
      check("inflight_rst.valid", {31'h0, rsp_valid}, 32'h0);
      check("inflight_rst.cnt", {16'h0, miss_cnt}, 32'h0);
      exp_miss  = 0;
      req_valid = 1'b0;
      rst       = 1'b0;
      step();
      lookup(32'h00222000, 2'b01, 1'b0, 1'b0);
      check_rsp("rst_clears_v", 1'b1, 5'b00010, 32'h0);

      // Reset in the middle of a sweep
      do_write(1'b1, '0, 8'h00, 20'h00333, 20'h00003, 6'h3F);
      do_write(1'b0, 3'd6, 8'h00, 20'h00666, 20'h00006, 6'h3F);
      inv_all = 1'b1;
      step();
      inv_all = 1'b0;
      check("midsweep.busy", {31'h0, busy}, 32'h1);
      step(); step();
      rst = 1'b1;
      #1;
      check("midsweep_rst.busy", {31'h0, busy}, 32'h0);
      check("midsweep_rst.ready", {31'h0, req_ready}, 32'h1);
      exp_miss = 0;
      step();
      rst = 1'b0;
      step();
      check("after_rst.busy", {31'h0, busy}, 32'h0);
      lookup(32'h00666000, 2'b01, 1'b0, 1'b0);
      check_rsp("midsweep_v6", 1'b1, 5'b00010, 32'h0);

      // Victim pointer restarts at 0 after reset
      do_write(1'b0, 3'd0, 8'h00, 20'h00444, 20'h00004, 6'h3F);
      do_write(1'b1, '0, 8'h00, 20'h00555, 20'h00005, 6'h3F);
      lookup(32'h00444000, 2'b01, 1'b0, 1'b0);
      check_rsp("victim_rst_over", 1'b1, 5'b00010, 32'h0);
      lookup(32'h00555123, 2'b01, 1'b0, 1'b0);
      check_rsp("victim_rst_new", 1'b0, 5'b00000, 32'h00005123);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
